spi_arbiter: RTL and testbench

- Shares one Spi master core (WIDTH-bit full-duplex transfer, one chip select) between N independent requesters.
- Round-robin grant, per-requester chip-select demultiplexing, word latching and a per-requester done pulse.
- Sits between client blocks (DAC, ADC, flash readers) and the single Spi instance on the board SPI bus.

---
 rtl/spi_arbiter.sv | 145 ++++++++++++++
 tb/tb_spi_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one SPI master core between N requesters.
// Round-robin grant, TX word latching, RX word capture, per-requester
// chip-select demultiplexing and a one-cycle done pulse per transfer.
// Optional watchdog: define SPI_ARB_TIMEOUT_EN to abort a transfer whose
// core_done never arrives (err + done pulse after TIMEOUT cycles in BUSY).
module spi_arbiter #(
    parameter int WIDTH   = 32,
    parameter int N       = 2,
    parameter int GW      = 3,
    parameter int TIMEOUT = 4096
) (
    input  logic                 CLK50MHZ,
    input  logic                 RST,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   wdata,
    output logic [WIDTH-1:0]     rdata,
    output logic [N-1:0]         done,
    output logic                 busy,
    output logic [GW-1:0]        gnt_idx,
    output logic                 err,
    output logic [WIDTH-1:0]     core_data_in,
    input  logic [WIDTH-1:0]     core_data_out,
    output logic                 core_trig,
    input  logic                 core_done,
    input  logic                 core_cs,
    output logic [N-1:0]         cs_n
);

    // Reject parameter sets the grant logic cannot represent.
    if (N < 2 || N > 8 || TIMEOUT < 2 || (1 << GW) < N) begin : g_param_check
        $error("spi_arbiter: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, LOAD, BUSY, FINISH} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            pick_valid;
    logic [GW-1:0]   pick_idx;
    logic            timeout_hit;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0]   tmo_cnt;

    // Watchdog counter: zero on the first BUSY cycle, +1 per BUSY cycle.
    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST)
            tmo_cnt <= '0;
        else if (state != BUSY)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    // A real core_done in the final cycle still wins over the abort.
    assign timeout_hit = (state == BUSY) && !core_done && (tmo_cnt == CW'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        int j;
        j          = 0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(gnt_idx) + k) % N;
            if (!pick_valid && req[j]) begin
                pick_valid = 1'b1;
                pick_idx   = GW'(j);
            end
        end
    end

    // State register.
    always_ff @(posedge CLK50MHZ or posedge RST) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (RST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_valid) state_nxt = LOAD;
            LOAD:    state_nxt = BUSY;
            BUSY: begin
                if (core_done)        state_nxt = FINISH;
                else if (timeout_hit) state_nxt = IDLE;
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered datapath: grant, TX latch, RX capture and busy flag.
    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            rdata        <= '0;
            busy         <= 1'b0;
            gnt_idx      <= GW'(N - 1);
            core_data_in <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        core_data_in <= wdata[int'(pick_idx)*WIDTH +: WIDTH];
                        gnt_idx      <= pick_idx;
                        busy         <= 1'b1;
                    end
                end
                BUSY: begin
                    if (core_done)
                        rdata <= core_data_out;
                    else if (timeout_hit)
                        busy <= 1'b0;
                end
                FINISH:  busy <= 1'b0;
                default: ;
            endcase
        end
    end

    // Decoded outputs: trigger, done pulse, error pulse and chip selects.
    always_comb begin
        core_trig = (state == LOAD);
        err       = timeout_hit;
        done      = '0;
        cs_n      = '1;
        for (int i = 0; i < N; i++) begin
            if (gnt_idx == GW'(i)) begin
                done[i] = (state == FINISH) || timeout_hit;
                if (busy)
                    cs_n[i] = core_cs;
            end
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed self-checking bench for spi_arbiter (N=2, WIDTH=32, TIMEOUT=16).
// The SPI core is emulated by driving core_cs/core_done/core_data_out directly.
module tb_spi_arbiter;

    localparam int WIDTH = 32;
    localparam int N     = 2;
    localparam int GW    = 3;

    logic               CLK50MHZ = 1'b0;
    logic               RST;
    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] wdata;
    logic [WIDTH-1:0]   rdata;
    logic [N-1:0]       done;
    logic               busy;
    logic [GW-1:0]      gnt_idx;
    logic               err;
    logic [WIDTH-1:0]   core_data_in;
    logic [WIDTH-1:0]   core_data_out;
    logic               core_trig;
    logic               core_done;
    logic               core_cs;
    logic [N-1:0]       cs_n;

    int n_tests = 0;
    int n_fail  = 0;

    spi_arbiter #(.WIDTH(WIDTH), .N(N), .GW(GW), .TIMEOUT(16)) dut (
        .CLK50MHZ      (CLK50MHZ),
        .RST           (RST),
        .req           (req),
        .wdata         (wdata),
        .rdata         (rdata),
        .done          (done),
        .busy          (busy),
        .gnt_idx       (gnt_idx),
        .err           (err),
        .core_data_in  (core_data_in),
        .core_data_out (core_data_out),
        .core_trig     (core_trig),
        .core_done     (core_done),
        .core_cs       (core_cs),
        .cs_n          (cs_n)
    );

    always #5 CLK50MHZ = ~CLK50MHZ;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge CLK50MHZ);
        #1;
    endtask

    task automatic apply_reset(input logic [N-1:0] req_val);
        RST           = 1'b1;
        req           = req_val;
        core_done     = 1'b0;
        core_cs       = 1'b1;
        core_data_out = '0;
        tick();
        RST = 1'b0;
    endtask

    // One full transfer starting in IDLE with a request pending, ending back in IDLE.
    task automatic run_xfer(input logic [N-1:0] req_mid, input logic [N-1:0] req_end,
                            input logic [WIDTH-1:0] rx,
                            output logic trig_o, output logic [GW-1:0] gnt_o,
                            output logic [WIDTH-1:0] tx_o, output logic [N-1:0] cs_o,
                            output logic [N-1:0] done_o, output logic [WIDTH-1:0] rdata_o,
                            output logic [N-1:0] done_after_o, output logic busy_after_o);
        tick();                       // grant -> LOAD
        trig_o = core_trig;
        gnt_o  = gnt_idx;
        tx_o   = core_data_in;
        req    = req_mid;
        tick();                       // BUSY
        core_cs = 1'b0;
        #1;
        cs_o = cs_n;
        tick();
        core_data_out = rx;
        core_done     = 1'b1;
        tick();                       // FINISH
        core_done = 1'b0;
        core_cs   = 1'b1;
        done_o    = done;
        rdata_o   = rdata;
        req       = req_end;
        tick();                       // IDLE
        done_after_o = done;
        busy_after_o = busy;
    endtask

    task automatic test_reset();
        RST           = 1'b1;
        req           = '0;
        wdata         = '0;
        core_done     = 1'b0;
        core_cs       = 1'b1;
        core_data_out = '0;
        #12;
        n_tests++; if (rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        n_tests++; if (done !== 2'b00) begin n_fail++; $display("FAIL reset_done: got %b want 00", done); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (gnt_idx !== 3'd1) begin n_fail++; $display("FAIL reset_gnt: got %0d want 1", gnt_idx); end
        n_tests++; if (core_trig !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_trig_err: got %b%b want 00", core_trig, err); end
        n_tests++; if (core_data_in !== '0) begin n_fail++; $display("FAIL reset_core_data_in: got %h want 0", core_data_in); end
        n_tests++; if (cs_n !== 2'b11) begin n_fail++; $display("FAIL reset_cs_n: got %b want 11", cs_n); end
    endtask

    task automatic test_single();
        logic trig; logic [GW-1:0] g; logic [WIDTH-1:0] tx, rd;
        logic [N-1:0] cs, dn, dn_after; logic bz;
        apply_reset(2'b00);
        wdata = {32'hDEAD_BEEF, 32'hA5A5_0001};
        req   = 2'b01;
        n_tests++; if (core_trig !== 1'b0) begin n_fail++; $display("FAIL single_trig_early: got %b want 0", core_trig); end
        run_xfer(2'b01, 2'b00, 32'h1234_5678, trig, g, tx, cs, dn, rd, dn_after, bz);
        n_tests++; if (trig !== 1'b1) begin n_fail++; $display("FAIL single_trig: got %b want 1", trig); end
        n_tests++; if (g !== 3'd0) begin n_fail++; $display("FAIL single_gnt: got %0d want 0", g); end
        n_tests++; if (tx !== 32'hA5A5_0001) begin n_fail++; $display("FAIL single_tx: got %h want a5a50001", tx); end
        n_tests++; if (cs !== 2'b10) begin n_fail++; $display("FAIL single_cs_n: got %b want 10", cs); end
        n_tests++; if (dn !== 2'b01) begin n_fail++; $display("FAIL single_done: got %b want 01", dn); end
        n_tests++; if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL single_rdata: got %h want 12345678", rd); end
        n_tests++; if (dn_after !== 2'b00 || bz !== 1'b0) begin n_fail++; $display("FAIL single_after: got done=%b busy=%b want 00/0", dn_after, bz); end
    endtask

    task automatic test_round_robin();
        logic trig; logic [GW-1:0] g; logic [WIDTH-1:0] tx, rd;
        logic [N-1:0] cs, dn, dn_after; logic bz;
        logic [GW-1:0] exp_g;
        apply_reset(2'b11);
        wdata = {32'h1111_0000, 32'h0000_2222};
        for (int k = 0; k < 4; k++) begin
            exp_g = GW'(k % 2);
            run_xfer(2'b11, 2'b11, 32'hC0DE_0000 + WIDTH'(k), trig, g, tx, cs, dn, rd, dn_after, bz);
            n_tests++; if (g !== exp_g) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %0d want %0d", k, g, exp_g); end
            n_tests++; if (tx !== ((k % 2 == 0) ? 32'h0000_2222 : 32'h1111_0000)) begin n_fail++; $display("FAIL rr_tx[%0d]: got %h", k, tx); end
            n_tests++; if (cs !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rr_cs_n[%0d]: got %b", k, cs); end
            n_tests++; if (dn !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL rr_done[%0d]: got %b", k, dn); end
            n_tests++; if (rd !== 32'hC0DE_0000 + WIDTH'(k)) begin n_fail++; $display("FAIL rr_rdata[%0d]: got %h", k, rd); end
        end
        req = 2'b00;
        tick();
    endtask

    task automatic test_drop_req();
        logic trig; logic [GW-1:0] g; logic [WIDTH-1:0] tx, rd;
        logic [N-1:0] cs, dn, dn_after; logic bz;
        apply_reset(2'b00);
        wdata = {32'h0BAD_F00D, 32'h0};
        req   = 2'b10;
        run_xfer(2'b00, 2'b00, 32'h5555_AAAA, trig, g, tx, cs, dn, rd, dn_after, bz);
        n_tests++; if (g !== 3'd1 || cs !== 2'b01) begin n_fail++; $display("FAIL drop_gnt_cs: got gnt=%0d cs_n=%b want 1/01", g, cs); end
        n_tests++; if (dn !== 2'b10) begin n_fail++; $display("FAIL drop_done: got %b want 10", dn); end
        tick();
        tick();
        n_tests++; if (busy !== 1'b0 || core_trig !== 1'b0) begin n_fail++; $display("FAIL drop_idle: got busy=%b trig=%b want 0/0", busy, core_trig); end
    endtask

    task automatic test_idle_core_done();
        logic trig; logic [GW-1:0] g; logic [WIDTH-1:0] tx, rd;
        logic [N-1:0] cs, dn, dn_after; logic bz;
        apply_reset(2'b00);
        wdata = {32'h0, 32'h7777_0000};
        req   = 2'b01;
        run_xfer(2'b01, 2'b00, 32'h1111_2222, trig, g, tx, cs, dn, rd, dn_after, bz);
        core_data_out = 32'hCAFE_F00D;
        core_done     = 1'b1;
        tick();
        core_done = 1'b0;
        n_tests++; if (done !== 2'b00) begin n_fail++; $display("FAIL idle_done: got %b want 00", done); end
        tick();
        n_tests++; if (rdata !== 32'h1111_2222) begin n_fail++; $display("FAIL idle_rdata: got %h want 11112222", rdata); end
        n_tests++; if (busy !== 1'b0 || done !== 2'b00) begin n_fail++; $display("FAIL idle_state: got busy=%b done=%b", busy, done); end
    endtask

    task automatic test_async_reset();
        apply_reset(2'b00);
        wdata = {32'h0, 32'h9999_8888};
        req   = 2'b01;
        tick();               // LOAD
        tick();               // BUSY
        core_cs = 1'b0;
        #1;
        n_tests++; if (cs_n !== 2'b10 || busy !== 1'b1) begin n_fail++; $display("FAIL arst_pre: got cs_n=%b busy=%b want 10/1", cs_n, busy); end
        #1;                   // mid-cycle, away from any clock edge
        RST = 1'b1;
        #1;
        n_tests++; if (busy !== 1'b0 || cs_n !== 2'b11) begin n_fail++; $display("FAIL arst_busy_cs: got busy=%b cs_n=%b want 0/11", busy, cs_n); end
        n_tests++; if (done !== 2'b00 || core_trig !== 1'b0 || core_data_in !== '0) begin n_fail++; $display("FAIL arst_outputs: got done=%b trig=%b din=%h", done, core_trig, core_data_in); end
        n_tests++; if (gnt_idx !== 3'd1 || rdata !== '0) begin n_fail++; $display("FAIL arst_gnt_rdata: got gnt=%0d rdata=%h want 1/0", gnt_idx, rdata); end
        req     = 2'b00;
        core_cs = 1'b1;
        tick();
        RST = 1'b0;
    endtask

`ifdef SPI_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int waited;
        logic [WIDTH-1:0] rd_before;
        apply_reset(2'b00);
        wdata = {32'h0, 32'h4444_3333};
        req   = 2'b01;
        tick();               // LOAD
        tick();               // first BUSY cycle
        core_cs   = 1'b0;
        rd_before = rdata;
        waited    = 0;
        while (err !== 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        n_tests++; if (waited !== 15) begin n_fail++; $display("FAIL tmo_latency: got %0d cycles after first BUSY cycle want 15", waited); end
        n_tests++; if (done !== 2'b01) begin n_fail++; $display("FAIL tmo_done: got %b want 01", done); end
        n_tests++; if (rdata !== rd_before) begin n_fail++; $display("FAIL tmo_rdata: got %h want %h", rdata, rd_before); end
        req     = 2'b00;
        core_cs = 1'b1;
        tick();
        n_tests++; if (busy !== 1'b0 || err !== 1'b0 || done !== 2'b00) begin n_fail++; $display("FAIL tmo_idle: got busy=%b err=%b done=%b", busy, err, done); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_drop_req();
        test_idle_core_done();
        test_async_reset();
`ifdef SPI_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
